// File: rtl/clock_pkg.sv
// Shared types and field limits for the T1 time-of-day controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int SECONDS_MAX = 59;

endpackage

// File: rtl/clock_time_ctrl_tick_gen.sv
// Prescaler producing a half-period enable and a full-period tick enable.
// Sync clear restarts both the count and the half/full phase.
module tick_gen #(
  parameter int HALF = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic half_tick_o,
  output logic tick_o
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign half_tick_o = (cnt_q == CW'(HALF - 1));
  assign tick_o      = half_tick_o & phase_q;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_tick_o) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS time-of-day counters with a RUN/SET_HOUR/SET_MIN button FSM.
// All outputs are registered; a mode press always beats an increment or a tick.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       blink
);

  localparam int HALF = CLK_FREQ / (2 * TICK_HZ);

  mode_t      mode_q, mode_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic       sec_tick_q, sec_tick_d;
  logic       blink_q, blink_d;
  logic       blink_phase_q, blink_phase_d;
  logic       clr, half_tick, tick;

  tick_gen #(.HALF(HALF)) u_tick_gen (
    .clk_i       (clk_100MHz),
    .rst_i       (rst),
    .clr_i       (clr),
    .half_tick_o (half_tick),
    .tick_o      (tick)
  );

  always_comb begin
    mode_d        = mode_q;
    hours_d       = hours_q;
    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    sec_tick_d    = 1'b0;
    blink_phase_d = blink_phase_q;
    clr           = 1'b0;

    if (mode_q != RUN && half_tick)
      blink_phase_d = ~blink_phase_q;

    case (mode_q)
      RUN: begin
        if (btn_mode) begin
          mode_d        = SET_HOUR;
          seconds_d     = '0;
          blink_phase_d = 1'b0;
          clr           = 1'b1;
        end else if (tick) begin
          sec_tick_d = 1'b1;
          if (seconds_q == 6'(SECONDS_MAX)) begin
            seconds_d = '0;
            if (minutes_q == 6'(MINUTES_MAX)) begin
              minutes_d = '0;
              hours_d   = (hours_q == 5'(HOURS_MAX)) ? 5'd0 : hours_q + 5'd1;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
      end
      SET_HOUR: begin
        if (btn_mode)
          mode_d = SET_MIN;
        else if (btn_inc)
          hours_d = (hours_q == 5'(HOURS_MAX)) ? 5'd0 : hours_q + 5'd1;
      end
      SET_MIN: begin
        // Restarting the prescaler gives a full second before the first tick.
        if (btn_mode) begin
          mode_d = RUN;
          clr    = 1'b1;
        end else if (btn_inc) begin
          minutes_d = (minutes_q == 6'(MINUTES_MAX)) ? 6'd0 : minutes_q + 6'd1;
        end
      end
      default: begin
        mode_d = RUN;
        clr    = 1'b1;
      end
    endcase

    blink_d = (mode_d == SET_HOUR || mode_d == SET_MIN) ? blink_phase_d : 1'b0;
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      mode_q        <= RUN;
      hours_q       <= '0;
      minutes_q     <= '0;
      seconds_q     <= '0;
      sec_tick_q    <= 1'b0;
      blink_q       <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      hours_q       <= hours_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      sec_tick_q    <= sec_tick_d;
      blink_q       <= blink_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign mode     = mode_q;
  assign sec_tick = sec_tick_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl at CLK_FREQ=20, TICK_HZ=1 (HALF=10).
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       sec_tick;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;

  clock_time_ctrl #(.CLK_FREQ(20), .TICK_HZ(1)) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .mode       (mode),
    .sec_tick   (sec_tick),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m;
    logic i;
    int   reps;
    int   h;
    int   mi;
    int   s;
    int   md;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int mi, input int s);
    check({tag, "_hours"},   int'(hours),   h);
    check({tag, "_minutes"}, int'(minutes), mi);
    check({tag, "_seconds"}, int'(seconds), s);
  endtask

  initial begin
    int lat;

    vecs[0] = '{1'b1, 1'b0, 1,   0,  0, 0, 1};
    vecs[1] = '{1'b0, 1'b1, 25,  1,  0, 0, 1};
    vecs[2] = '{1'b1, 1'b0, 1,   1,  0, 0, 2};
    vecs[3] = '{1'b0, 1'b1, 61,  1,  1, 0, 2};
    vecs[4] = '{1'b1, 1'b1, 1,   1,  1, 0, 0};
    vecs[5] = '{1'b0, 1'b1, 3,   1,  1, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 1,   1,  1, 0, 1};
    vecs[7] = '{1'b0, 1'b1, 22, 23,  1, 0, 1};
    vecs[8] = '{1'b1, 1'b1, 1,  23,  1, 0, 2};
    vecs[9] = '{1'b0, 1'b1, 58, 23, 59, 0, 2};

    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_time("reset", 0, 0, 0);
    check("reset_mode", int'(mode), 0);
    check("reset_sec_tick", int'(sec_tick), 0);
    check("reset_blink", int'(blink), 0);

    rst = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      check($sformatf("freerun_sec_tick_c%0d", c), int'(sec_tick), (c % 20 == 0) ? 1 : 0);
    end
    check("freerun_seconds", int'(seconds), 3);

    for (int k = 0; k < 10; k++) begin
      for (int r = 0; r < vecs[k].reps; r++)
        press(vecs[k].m, vecs[k].i);
      check_time($sformatf("vec%0d", k), vecs[k].h, vecs[k].mi, vecs[k].s);
      check($sformatf("vec%0d_mode", k), int'(mode), vecs[k].md);
    end

    // Leave SET_MIN at 23:59:00; first tick must land exactly 20 cycles later.
    press(1'b1, 1'b0);
    check("exit_set_mode", int'(mode), 0);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (sec_tick) begin
        lat = c;
        break;
      end
    end
    check("first_tick_latency", lat, 20);
    check_time("after_first_tick", 23, 59, 1);

    repeat (57 * 20) step();
    check_time("preload", 23, 59, 58);
    repeat (20) step();
    check("tick59_pulse", int'(sec_tick), 1);
    check_time("at_59", 23, 59, 59);
    step();
    check("tick_width", int'(sec_tick), 0);
    repeat (19) step();
    check("wrap_pulse", int'(sec_tick), 1);
    check_time("wrap", 0, 0, 0);

    // Mode press on the same cycle as a full tick: tick is discarded.
    repeat (19) step();
    press(1'b1, 1'b0);
    check("collide_mode", int'(mode), 1);
    check("collide_seconds", int'(seconds), 0);
    check("collide_sec_tick", int'(sec_tick), 0);

    check("blink_k0", int'(blink), 0);
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("blink_set_k%0d", k), int'(blink), (k / 10) % 2);
    end

    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("back_to_run", int'(mode), 0);
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("blink_run_k%0d", k), int'(blink), 0);
    end

    press(1'b1, 1'b0);
    repeat (5) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("pre_reset_hours", int'(hours), 5);
    check("pre_reset_mode", int'(mode), 2);
    #3 rst = 1'b1;
    #1;
    check_time("async_reset", 0, 0, 0);
    check("async_reset_mode", int'(mode), 0);
    check("async_reset_blink", int'(blink), 0);
    check("async_reset_sec_tick", int'(sec_tick), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("post_reset_mode", int'(mode), 0);
    check("post_reset_hours", int'(hours), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
